sprite_write_master: RTL and testbench



---
 rtl/sprite_write_master.sv | 199 +++++++++++++++++++
 tb/tb_sprite_write_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_write_master.sv
// sprite_write_master
// Collects sprite register updates from game logic in a FIFO. On commit it
// replays the whole batch as back-to-back Avalon-MM single-cycle writes, and
// only while vertical blank is high, so the sprite table never tears mid-frame.
module sprite_write_master #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [ADDR_W-1:0]          upd_addr,
  input  logic [DATA_W-1:0]          upd_data,
  input  logic                       commit,
  input  logic                       vblank,
  input  logic                       clear_err,
  output logic [ADDR_W-1:0]          address,
  output logic [DATA_W-1:0]          gl_input,
  output logic                       write,
  output logic                       chipselect,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       drop_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               vblank_q_r;
  logic [ENT_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [ADDR_W-1:0]  address_r;
  logic [DATA_W-1:0]  gl_input_r;
  logic               write_r;
  logic               chipselect_r;
  logic               busy_r;
  logic               done_r;
  logic               drop_err_r;
  logic               last_pop_r;

  logic               full_s;
  logic               empty_s;
  logic               ready_s;
  logic               hs_s;
  logic               addr_ok_s;
  logic               push_s;
  logic               bad_s;
  logic               vb_rise_s;
  logic               pop_s;
  logic               empty_commit_s;
  logic [ENT_W-1:0]   head_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign ready_s   = (state_r == S_IDLE) & ~full_s;
  assign hs_s      = upd_valid & ready_s;
  assign addr_ok_s = ({1'b0, upd_addr} < NUM_REGS_W);
  assign push_s    = hs_s & addr_ok_s;
  assign bad_s     = hs_s & ~addr_ok_s;
  assign vb_rise_s = vblank & ~vblank_q_r;
  assign head_s    = mem_r[rd_ptr_r];

  // Next-state logic: commit arms, vblank rise starts draining, vblank fall pauses
  always_comb begin
    state_nxt_s    = state_r;
    pop_s          = 1'b0;
    empty_commit_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (commit) begin
          if (!empty_s || push_s) begin
            state_nxt_s = S_ARMED;
          end else begin
            empty_commit_s = 1'b1;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ARMED: begin
        if (vb_rise_s) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_ARMED;
        end
      end
      S_DRAIN: begin
        if (vblank && !empty_s) begin
          pop_s = 1'b1;
          if (count_r == CNT_W'(1)) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_DRAIN;
          end
        end else if (!empty_s) begin
          // Blank ended with entries left: wait for the next frame's blank
          state_nxt_s = S_ARMED;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {upd_addr, upd_data};
    end
  end

  // State, FIFO bookkeeping, vblank edge history and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      vblank_q_r <= 1'b0;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      drop_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      vblank_q_r <= vblank;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      // Push only happens in IDLE and pop only in DRAIN, so never both
      if (push_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop_s) begin
        count_r <= count_r - CNT_W'(1);
      end
      // A new drop in the same cycle as clear_err keeps the flag set
      if (bad_s) begin
        drop_err_r <= 1'b1;
      end else if (clear_err) begin
        drop_err_r <= 1'b0;
      end
    end
  end

  // Registered Avalon write port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      address_r    <= {ADDR_W{1'b0}};
      gl_input_r   <= {DATA_W{1'b0}};
      write_r      <= 1'b0;
      chipselect_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      last_pop_r   <= 1'b0;
    end else begin
      write_r      <= pop_s;
      chipselect_r <= pop_s;
      if (pop_s) begin
        address_r  <= head_s[ENT_W-1:DATA_W];
        gl_input_r <= head_s[DATA_W-1:0];
      end
      // Busy stays up through the final write and falls together with done
      busy_r     <= (state_nxt_s != S_IDLE) | pop_s;
      last_pop_r <= pop_s & (state_nxt_s == S_IDLE);
      done_r     <= empty_commit_s | last_pop_r;
    end
  end

  assign upd_ready  = ready_s;
  assign address    = address_r;
  assign gl_input   = gl_input_r;
  assign write      = write_r;
  assign chipselect = chipselect_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pending    = count_r;
  assign drop_err   = drop_err_r;

endmodule

// File: tb/tb_sprite_write_master.sv
// Directed self-checking bench for sprite_write_master.
module tb_sprite_write_master;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_data;
  logic              commit;
  logic              vblank;
  logic              clear_err;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] gl_input;
  logic              write;
  logic              chipselect;
  logic              busy;
  logic              done;
  logic [5:0]        pending;
  logic              drop_err;

  int checks = 0;
  int errors = 0;

  sprite_write_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(20)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_addr(upd_addr), .upd_data(upd_data), .commit(commit), .vblank(vblank),
    .clear_err(clear_err), .address(address), .gl_input(gl_input), .write(write),
    .chipselect(chipselect), .busy(busy), .done(done), .pending(pending), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    upd_valid = 1'b1; upd_addr = a; upd_data = d;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1; upd_valid = 1'b0; upd_addr = 5'd0; upd_data = 32'd0;
    commit = 1'b0; vblank = 1'b0; clear_err = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %0b want 0", write); end
    checks++; if (chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %0b want 0", chipselect); end
    checks++; if (address !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", address); end
    checks++; if (gl_input !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", gl_input); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done); end
    checks++; if (pending !== 6'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b want 0", drop_err); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", upd_ready); end
  endtask

  task automatic test_batch_drain;
    logic [ADDR_W-1:0] ea [3];
    logic [DATA_W-1:0] ed [3];
    int stray;
    logic exp_w;
    ea[0] = 5'd0; ea[1] = 5'd3; ea[2] = 5'd19;
    ed[0] = 32'h11; ed[1] = 32'h22; ed[2] = 32'h33;
    do_reset();
    enq(5'd0, 32'h11); enq(5'd3, 32'h22); enq(5'd19, 32'h33);
    checks++; if (pending !== 6'd3) begin errors++; $display("FAIL batch_pending: got %0d want 3", pending); end
    commit = 1'b1; tick(); commit = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL batch_busy_armed: got %0b want 1", busy); end
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write !== 1'b0 || busy !== 1'b1) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL batch_wait: got %0d bad cycles want 0", stray); end
    vblank = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_w = (t >= 2 && t <= 4);
      checks++; if (write !== exp_w || chipselect !== exp_w) begin errors++; $display("FAIL batch_write_t%0d: got w=%0b cs=%0b want %0b", t, write, chipselect, exp_w); end
      if (exp_w) begin
        checks++; if (address !== ea[t-2] || gl_input !== ed[t-2]) begin errors++; $display("FAIL batch_entry_t%0d: got %0d/%0h want %0d/%0h", t, address, gl_input, ea[t-2], ed[t-2]); end
      end
      checks++; if (done !== (t == 5)) begin errors++; $display("FAIL batch_done_t%0d: got %0b want %0b", t, done, (t == 5)); end
      checks++; if (busy !== (t <= 4)) begin errors++; $display("FAIL batch_busy_t%0d: got %0b want %0b", t, busy, (t <= 4)); end
    end
    vblank = 1'b0;
  endtask

  task automatic test_split;
    int nw, bad, first, last_t, done_t, done_cnt;
    do_reset();
    for (int i = 0; i < 10; i++) enq(5'(i), 32'h100 + 32'(i));
    commit = 1'b1; tick(); commit = 1'b0;
    repeat (3) tick();
    nw = 0; bad = 0;
    vblank = 1'b1;
    for (int t = 0; t < 11; t++) begin
      if (t == 5) vblank = 1'b0;
      tick();
      if (write === 1'b1) begin
        if (address !== 5'(nw) || gl_input !== 32'h100 + 32'(nw)) bad++;
        nw++;
      end
    end
    first = nw;
    checks++; if (first !== 4) begin errors++; $display("FAIL split_first_blank: got %0d writes want 4", first); end
    checks++; if (busy !== 1'b1 || pending !== 6'd6) begin errors++; $display("FAIL split_paused: got busy=%0b pending=%0d want 1/6", busy, pending); end
    vblank = 1'b1;
    last_t = -10; done_t = -1; done_cnt = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (write === 1'b1) begin
        if (address !== 5'(nw) || gl_input !== 32'h100 + 32'(nw)) bad++;
        nw++;
        if (nw == 10) last_t = t;
      end
      if (done === 1'b1) begin done_cnt++; done_t = t; end
    end
    vblank = 1'b0;
    checks++; if (nw - first !== 6) begin errors++; $display("FAIL split_second_blank: got %0d writes want 6", nw - first); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL split_order: got %0d bad writes want 0", bad); end
    checks++; if (done_cnt !== 1 || done_t !== last_t + 1) begin errors++; $display("FAIL split_done: got cnt=%0d at %0d want 1 at %0d", done_cnt, done_t, last_t + 1); end
  endtask

  task automatic test_empty_and_ignored_commit;
    int nw, dc;
    do_reset();
    commit = 1'b1; tick(); commit = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL empty_commit: got d=%0b b=%0b w=%0b want 1 0 0", done, busy, write); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_after: got d=%0b b=%0b want 0 0", done, busy); end
    enq(5'd7, 32'h77); enq(5'd8, 32'h88);
    commit = 1'b1; tick(); commit = 1'b0; tick();
    commit = 1'b1; tick(); commit = 1'b0;
    checks++; if (pending !== 6'd2 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ignored_commit: got p=%0d b=%0b d=%0b want 2 1 0", pending, busy, done); end
    vblank = 1'b1; nw = 0; dc = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (write === 1'b1) nw++;
      if (done === 1'b1) dc++;
    end
    vblank = 1'b0;
    checks++; if (nw !== 2 || dc !== 1) begin errors++; $display("FAIL ignored_drain: got %0d writes %0d done want 2 1", nw, dc); end
  endtask

  task automatic test_drop;
    do_reset();
    enq(5'd1, 32'h1); enq(5'd2, 32'h2); enq(5'd3, 32'h3);
    upd_valid = 1'b1; upd_addr = 5'd25; upd_data = 32'hDEAD;
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %0b want 1", upd_ready); end
    tick(); upd_valid = 1'b0;
    checks++; if (drop_err !== 1'b1 || pending !== 6'd3) begin errors++; $display("FAIL drop_set: got e=%0b p=%0d want 1 3", drop_err, pending); end
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL drop_clear: got %0b want 0", drop_err); end
    upd_valid = 1'b1; upd_addr = 5'd20; clear_err = 1'b1; tick(); upd_valid = 1'b0; clear_err = 1'b0;
    checks++; if (drop_err !== 1'b1 || pending !== 6'd3) begin errors++; $display("FAIL drop_set_wins: got e=%0b p=%0d want 1 3", drop_err, pending); end
  endtask

  task automatic test_full;
    int nw, bad;
    do_reset();
    upd_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      upd_addr = 5'(i % 20); upd_data = 32'(i);
      checks++; if (upd_ready !== (i < 32)) begin errors++; $display("FAIL full_ready_%0d: got %0b want %0b", i, upd_ready, (i < 32)); end
      tick();
    end
    upd_valid = 1'b0;
    checks++; if (pending !== 6'd32) begin errors++; $display("FAIL full_pending: got %0d want 32", pending); end
    commit = 1'b1; tick(); commit = 1'b0;
    vblank = 1'b1; nw = 0; bad = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (write === 1'b1) begin
        if (address !== 5'(nw % 20) || gl_input !== 32'(nw)) bad++;
        nw++;
      end
    end
    vblank = 1'b0;
    checks++; if (nw !== 32 || bad !== 0) begin errors++; $display("FAIL full_drain: got %0d writes %0d bad want 32 0", nw, bad); end
    checks++; if (pending !== 6'd0 || busy !== 1'b0) begin errors++; $display("FAIL full_end: got p=%0d b=%0b want 0 0", pending, busy); end
  endtask

  task automatic test_commit_at_vblank_high;
    int nw, first_t;
    do_reset();
    vblank = 1'b1; tick(); tick();
    enq(5'd9, 32'h99); enq(5'd10, 32'hAA);
    commit = 1'b1; tick(); commit = 1'b0;
    nw = 0;
    repeat (6) begin tick(); if (write === 1'b1) nw++; end
    vblank = 1'b0;
    repeat (2) begin tick(); if (write === 1'b1) nw++; end
    checks++; if (nw !== 0 || busy !== 1'b1) begin errors++; $display("FAIL vbhigh_wait: got %0d writes busy=%0b want 0 1", nw, busy); end
    vblank = 1'b1; first_t = -1;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (write === 1'b1) begin
        if (first_t < 0) first_t = t;
        nw++;
      end
    end
    vblank = 1'b0;
    checks++; if (nw !== 2 || first_t !== 1) begin errors++; $display("FAIL vbhigh_drain: got %0d writes first at %0d want 2 at 1", nw, first_t); end
  endtask

  task automatic test_reset_mid_drain;
    int nw;
    do_reset();
    for (int i = 0; i < 5; i++) enq(5'(5 + i), 32'hA0 + 32'(i));
    commit = 1'b1; tick(); commit = 1'b0; tick();
    vblank = 1'b1;
    tick(); tick(); tick();
    checks++; if (write !== 1'b1 || address !== 5'd6 || gl_input !== 32'hA1) begin errors++; $display("FAIL midrst_second: got w=%0b %0d/%0h want 1 6/a1", write, address, gl_input); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (write !== 1'b0 || pending !== 6'd0 || busy !== 1'b0 || upd_ready !== 1'b1) begin errors++; $display("FAIL midrst_after: got w=%0b p=%0d b=%0b r=%0b want 0 0 0 1", write, pending, busy, upd_ready); end
    vblank = 1'b0; repeat (3) tick();
    vblank = 1'b1; nw = 0;
    repeat (8) begin tick(); if (write === 1'b1) nw++; end
    vblank = 1'b0;
    checks++; if (nw !== 0) begin errors++; $display("FAIL midrst_nowrite: got %0d writes want 0", nw); end
  endtask

  initial begin
    test_reset();
    test_batch_drain();
    test_split();
    test_empty_and_ignored_commit();
    test_drop();
    test_full();
    test_commit_at_vblank_high();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
